// File: rtl/legv8_instr_encoder.sv
// legv8_instr_encoder: LDUR/STUR/ADD/SUB/AND/ORR/CBZ/B request -> 32-bit LEGv8 word, queued in a FWFT FIFO.
// Latency: word visible the cycle after acceptance into an empty FIFO. Backpressure: ReqReady falls when
// free entries < 1 (< 2 with ENC_BRANCH_BUBBLE_EN, which appends ORR XZR,XZR,XZR after every branch).

// legv8_enc_fifo: first-word-fall-through word queue with an optional second write lane.
// Latency: head visible the cycle after the write. Backpressure: none internally, caller must check count.
module legv8_enc_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                     core_clk,
  input  logic                     rst,
  input  logic                     wr_vld,
  input  logic [W-1:0]             wr_dat,
  input  logic                     wr2_vld,
  input  logic [W-1:0]             wr2_dat,
  input  logic                     rd_rdy,
  output logic                     rd_vld,
  output logic [W-1:0]             rd_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr_nx;
  logic [CW-1:0] n_in;
  logic          pop;

  assign rd_vld    = (count != '0);
  assign rd_dat    = rd_vld ? mem[rd_ptr] : '0;
  assign pop       = rd_vld && rd_rdy;
  assign wr_ptr_nx = wr_ptr + AW'(1);

  // The second lane only ever follows a primary write, so it lands in the very next slot.
  always_comb begin
    n_in = '0;
    if (wr_vld) n_in = (wr2_vld) ? CW'(2) : CW'(1);
  end

  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(n_in);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + n_in - CW'(pop);
    end
  end

  always_ff @(posedge core_clk) begin
    if (wr_vld)            mem[wr_ptr]    <= wr_dat;
    if (wr_vld && wr2_vld) mem[wr_ptr_nx] <= wr2_dat;
  end
endmodule

module legv8_instr_encoder #(
  parameter int DEPTH = 4,
  parameter int ERRW  = 8
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            ReqValid,
  output logic            ReqReady,
  input  logic [2:0]      ReqOp,
  input  logic [4:0]      ReqRd,
  input  logic [4:0]      ReqRn,
  input  logic [4:0]      ReqRm,
  input  logic [25:0]     ReqImm,
  output logic            InstrValid,
  input  logic            InstrReady,
  output logic [31:0]     Instr,
  output logic            RangeErr,
  output logic [ERRW-1:0] ErrCount
);
  localparam int CW = $clog2(DEPTH) + 1;
`ifdef ENC_BRANCH_BUBBLE_EN
  localparam int NEED = 2;
`else
  localparam int NEED = 1;
`endif
  localparam logic [CW-1:0] READY_LIM = CW'(DEPTH - NEED);
  localparam logic [31:0]   BUBBLE    = 32'hAA1F03FF;

  localparam logic [2:0] OP_LDUR = 3'd0;
  localparam logic [2:0] OP_STUR = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_ORR  = 3'd5;
  localparam logic [2:0] OP_CBZ  = 3'd6;
  localparam logic [2:0] OP_B    = 3'd7;

  typedef struct packed {
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic [25:0] imm;
  } req_t;

  req_t          req;
  logic [31:0]   enc_dat;
  logic          enc_ok;
  logic          d_ok;
  logic          cb_ok;
  logic          accept;
  logic          push_vld;
  logic          push2_vld;
  logic          drop;
  logic [CW-1:0] fifo_count;

  assign req = {ReqOp, ReqRd, ReqRn, ReqRm, ReqImm};

  // In range means every bit above the field's sign bit copies it.
  assign d_ok  = (req.imm[25:8] == '0)  || (req.imm[25:8] == '1);
  assign cb_ok = (req.imm[25:18] == '0) || (req.imm[25:18] == '1);

  always_comb begin
    enc_dat = '0;
    enc_ok  = 1'b1;
    case (req.op)
      OP_LDUR: begin
        enc_dat = {11'b11111000010, req.imm[8:0], 2'b00, req.rn, req.rd};
        enc_ok  = d_ok;
      end
      OP_STUR: begin
        enc_dat = {11'b11111000000, req.imm[8:0], 2'b00, req.rn, req.rd};
        enc_ok  = d_ok;
      end
      OP_ADD:  enc_dat = {11'b10001011000, req.rm, 6'b0, req.rn, req.rd};
      OP_SUB:  enc_dat = {11'b11001011000, req.rm, 6'b0, req.rn, req.rd};
      OP_AND:  enc_dat = {11'b10001010000, req.rm, 6'b0, req.rn, req.rd};
      OP_ORR:  enc_dat = {11'b10101010000, req.rm, 6'b0, req.rn, req.rd};
      OP_CBZ: begin
        enc_dat = {8'b10110100, req.imm[18:0], req.rd};
        enc_ok  = cb_ok;
      end
      OP_B:    enc_dat = {6'b000101, req.imm};
      default: enc_dat = '0;
    endcase
  end

  // Readiness looks only at the registered occupancy, so a same-cycle pop never admits a push.
  assign ReqReady = (fifo_count <= READY_LIM);
  assign accept   = ReqValid && ReqReady;
  assign push_vld = accept && enc_ok;
  assign drop     = accept && !enc_ok;

`ifdef ENC_BRANCH_BUBBLE_EN
  assign push2_vld = push_vld && ((req.op == OP_CBZ) || (req.op == OP_B));
`else
  assign push2_vld = 1'b0;
`endif

  legv8_enc_fifo #(
    .DEPTH (DEPTH),
    .W     (32)
  ) u_fifo (
    .core_clk (CLK),
    .rst      (Reset),
    .wr_vld   (push_vld),
    .wr_dat   (enc_dat),
    .wr2_vld  (push2_vld),
    .wr2_dat  (BUBBLE),
    .rd_rdy   (InstrReady),
    .rd_vld   (InstrValid),
    .rd_dat   (Instr),
    .count    (fifo_count)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      RangeErr <= 1'b0;
      ErrCount <= '0;
    end else begin
      RangeErr <= drop;
      if (drop && (ErrCount != '1)) ErrCount <= ErrCount + ERRW'(1);
    end
  end
endmodule

// File: tb/tb_legv8_instr_encoder.sv
// Directed bench for legv8_instr_encoder; build with +define+ENC_BRANCH_BUBBLE_EN to cover bubble insertion.
`timescale 1ns/1ps
module tb_legv8_instr_encoder;
  localparam int DEPTH = 4;
  localparam int ERRW  = 8;
`ifdef ENC_BRANCH_BUBBLE_EN
  localparam int NFILL = DEPTH - 1;
`else
  localparam int NFILL = DEPTH;
`endif
  localparam logic [31:0] NOP = 32'hAA1F03FF;

  logic            CLK = 1'b0;
  logic            Reset = 1'b1;
  logic            ReqValid = 1'b0;
  logic            ReqReady;
  logic [2:0]      ReqOp = '0;
  logic [4:0]      ReqRd = '0;
  logic [4:0]      ReqRn = '0;
  logic [4:0]      ReqRm = '0;
  logic [25:0]     ReqImm = '0;
  logic            InstrValid;
  logic            InstrReady = 1'b0;
  logic [31:0]     Instr;
  logic            RangeErr;
  logic [ERRW-1:0] ErrCount;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  legv8_instr_encoder #(.DEPTH(DEPTH), .ERRW(ERRW)) dut (
    .CLK(CLK), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqOp(ReqOp), .ReqRd(ReqRd), .ReqRn(ReqRn), .ReqRm(ReqRm), .ReqImm(ReqImm),
    .InstrValid(InstrValid), .InstrReady(InstrReady), .Instr(Instr),
    .RangeErr(RangeErr), .ErrCount(ErrCount)
  );

  task automatic put(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rn,
                     input logic [4:0] rm, input logic [25:0] imm);
    ReqValid = 1'b1; ReqOp = op; ReqRd = rd; ReqRn = rn; ReqRm = rm; ReqImm = imm;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge CLK);
    checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", InstrValid); end
    checks++; if (Instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h want 00000000", Instr); end
    checks++; if (RangeErr !== 1'b0) begin errors++; $display("FAIL rst_rangeerr: got %b want 0", RangeErr); end
    checks++; if (ErrCount !== 8'd0) begin errors++; $display("FAIL rst_errcount: got %0d want 0", ErrCount); end
    Reset = 1'b0;
    @(negedge CLK);
    checks++; if (ReqReady !== 1'b1) begin errors++; $display("FAIL rst_reqready: got %b want 1", ReqReady); end
  endtask

  task automatic test_rtype();
    logic [2:0]  ops [4] = '{3'd2, 3'd3, 3'd4, 3'd5};
    logic [4:0]  rds [4] = '{5'd1, 5'd31, 5'd4, 5'd0};
    logic [4:0]  rns [4] = '{5'd2, 5'd0, 5'd5, 5'd31};
    logic [4:0]  rms [4] = '{5'd3, 5'd17, 5'd6, 5'd31};
    logic [31:0] exp [4] = '{32'h8B030041, 32'hCB11001F, 32'h8A0600A4, 32'hAA1F03E0};
    InstrReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      put(ops[i], rds[i], rns[i], rms[i], 26'h3FFFFFF);
      @(negedge CLK);
      ReqValid = 1'b0;
      checks++; if (InstrValid !== 1'b1) begin errors++; $display("FAIL rtype_valid[%0d]: got %b want 1", i, InstrValid); end
      checks++; if (Instr !== exp[i]) begin errors++; $display("FAIL rtype_word[%0d]: got %h want %h", i, Instr, exp[i]); end
      @(negedge CLK);
      checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL rtype_drained[%0d]: got %b want 0", i, InstrValid); end
    end
  endtask

  task automatic test_dtype();
    logic [2:0]  ops [3] = '{3'd0, 3'd1, 3'd0};
    logic [4:0]  rds [3] = '{5'd5, 5'd1, 5'd0};
    logic [4:0]  rns [3] = '{5'd6, 5'd2, 5'd0};
    logic [25:0] ims [3] = '{26'd8, 26'h3FFFF00, 26'd255};
    logic [31:0] exp [3] = '{32'hF84080C5, 32'hF8100041, 32'hF84FF000};
    InstrReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      put(ops[i], rds[i], rns[i], 5'd31, ims[i]);
      @(negedge CLK);
      ReqValid = 1'b0;
      checks++; if (Instr !== exp[i]) begin errors++; $display("FAIL dtype_word[%0d]: got %h want %h", i, Instr, exp[i]); end
      checks++; if (RangeErr !== 1'b0) begin errors++; $display("FAIL dtype_noerr[%0d]: got %b want 0", i, RangeErr); end
      @(negedge CLK);
    end
    put(3'd0, 5'd5, 5'd6, 5'd0, 26'd256);
    @(negedge CLK);
    ReqValid = 1'b0;
    checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL dtype_drop_valid: got %b want 0", InstrValid); end
    checks++; if (RangeErr !== 1'b1) begin errors++; $display("FAIL dtype_drop_pulse: got %b want 1", RangeErr); end
    checks++; if (ErrCount !== 8'd1) begin errors++; $display("FAIL dtype_drop_count: got %0d want 1", ErrCount); end
    @(negedge CLK);
    checks++; if (RangeErr !== 1'b0) begin errors++; $display("FAIL dtype_pulse_end: got %b want 0", RangeErr); end
    put(3'd1, 5'd0, 5'd0, 5'd0, 26'h3FFFEFF);
    @(negedge CLK);
    ReqValid = 1'b0;
    checks++; if (ErrCount !== 8'd2) begin errors++; $display("FAIL dtype_neg_drop: got %0d want 2", ErrCount); end
    @(negedge CLK);
  endtask

  task automatic test_branch();
    logic [2:0]  ops [4] = '{3'd6, 3'd7, 3'd7, 3'd6};
    logic [4:0]  rds [4] = '{5'd9, 5'd12, 5'd5, 5'd0};
    logic [25:0] ims [4] = '{26'h3FFFFFE, 26'd3, 26'h3FFFFFF, 26'h3FC0000};
    logic [31:0] exp [4] = '{32'hB4FFFFC9, 32'h14000003, 32'h17FFFFFF, 32'hB4800000};
    InstrReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      put(ops[i], rds[i], 5'd7, 5'd7, ims[i]);
      @(negedge CLK);
      ReqValid = 1'b0;
      checks++; if (Instr !== exp[i]) begin errors++; $display("FAIL branch_word[%0d]: got %h want %h", i, Instr, exp[i]); end
      @(negedge CLK);
`ifdef ENC_BRANCH_BUBBLE_EN
      checks++; if (Instr !== NOP) begin errors++; $display("FAIL branch_bubble[%0d]: got %h want %h", i, Instr, NOP); end
      @(negedge CLK);
`endif
      checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL branch_drained[%0d]: got %b want 0", i, InstrValid); end
    end
    put(3'd6, 5'd9, 5'd0, 5'd0, 26'h0040000);
    @(negedge CLK);
    ReqValid = 1'b0;
    checks++; if (RangeErr !== 1'b1) begin errors++; $display("FAIL cbz_drop_pulse: got %b want 1", RangeErr); end
    checks++; if (ErrCount !== 8'd3) begin errors++; $display("FAIL cbz_drop_count: got %0d want 3", ErrCount); end
    @(negedge CLK);
    checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL cbz_drop_nobubble: got %b want 0", InstrValid); end
  endtask

  task automatic test_back_to_back();
    InstrReady = 1'b1;
    put(3'd2, 5'd7, 5'd1, 5'd2, 26'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (i < 2) put(3'd2, 5'(8 + i), 5'd1, 5'd2, 26'd0);
      else ReqValid = 1'b0;
      checks++; if (Instr !== (32'h8B020027 + 32'(i))) begin errors++; $display("FAIL b2b_word[%0d]: got %h want %h", i, Instr, 32'h8B020027 + 32'(i)); end
      checks++; if (ReqReady !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, ReqReady); end
    end
    @(negedge CLK);
    checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b want 0", InstrValid); end
  endtask

  task automatic test_backpressure();
    InstrReady = 1'b0;
    for (int i = 0; i < NFILL; i++) begin
      checks++; if (ReqReady !== 1'b1) begin errors++; $display("FAIL bp_ready[%0d]: got %b want 1", i, ReqReady); end
      put(3'd2, 5'(i + 1), 5'd2, 5'd3, 26'd0);
      @(negedge CLK);
      checks++; if (Instr !== 32'h8B030041) begin errors++; $display("FAIL bp_head[%0d]: got %h want 8b030041", i, Instr); end
    end
    ReqValid = 1'b0;
    checks++; if (ReqReady !== 1'b0) begin errors++; $display("FAIL bp_full: got %b want 0", ReqReady); end
    @(negedge CLK);
    checks++; if (Instr !== 32'h8B030041) begin errors++; $display("FAIL bp_hold: got %h want 8b030041", Instr); end
    put(3'd2, 5'd20, 5'd2, 5'd3, 26'd0);
    InstrReady = 1'b1;
    @(negedge CLK);
    ReqValid = 1'b0;
    checks++; if (ReqReady !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %b want 1", ReqReady); end
    checks++; if (Instr !== 32'h8B030042) begin errors++; $display("FAIL bp_order[2]: got %h want 8b030042", Instr); end
    for (int k = 3; k <= NFILL; k++) begin
      @(negedge CLK);
      checks++; if (Instr !== (32'h8B030040 | 32'(k))) begin errors++; $display("FAIL bp_order[%0d]: got %h want %h", k, Instr, 32'h8B030040 | 32'(k)); end
    end
    @(negedge CLK);
    checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL bp_no_push_when_full: got %b want 0", InstrValid); end
  endtask

  task automatic test_saturate();
    InstrReady = 1'b1;
    put(3'd1, 5'd0, 5'd0, 5'd0, 26'd300);
    repeat (260) @(negedge CLK);
    checks++; if (ErrCount !== 8'd255) begin errors++; $display("FAIL sat_count: got %0d want 255", ErrCount); end
    checks++; if (RangeErr !== 1'b1) begin errors++; $display("FAIL sat_pulse: got %b want 1", RangeErr); end
    ReqValid = 1'b0;
    @(negedge CLK);
    checks++; if (ErrCount !== 8'd255) begin errors++; $display("FAIL sat_hold: got %0d want 255", ErrCount); end
    checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL sat_nothing_pushed: got %b want 0", InstrValid); end
  endtask

  task automatic test_reset_mid();
    Reset = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
    InstrReady = 1'b0;
    put(3'd0, 5'd0, 5'd0, 5'd0, 26'd512);
    repeat (5) @(negedge CLK);
    for (int i = 1; i <= 3; i++) begin
      put(3'd2, 5'(i), 5'd2, 5'd3, 26'd0);
      @(negedge CLK);
    end
    ReqValid = 1'b0;
    @(negedge CLK);
    checks++; if (ErrCount !== 8'd5) begin errors++; $display("FAIL mid_pre_count: got %0d want 5", ErrCount); end
    checks++; if (Instr !== 32'h8B030041) begin errors++; $display("FAIL mid_pre_head: got %h want 8b030041", Instr); end
    @(posedge CLK);
    #2 Reset = 1'b1;
    #1;
    checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL mid_async_valid: got %b want 0", InstrValid); end
    checks++; if (ErrCount !== 8'd0) begin errors++; $display("FAIL mid_async_count: got %0d want 0", ErrCount); end
    checks++; if (Instr !== 32'h0) begin errors++; $display("FAIL mid_async_instr: got %h want 00000000", Instr); end
    @(negedge CLK);
    Reset = 1'b0;
    InstrReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL mid_stale[%0d]: got %b want 0 (Instr %h)", i, InstrValid, Instr); end
    end
    checks++; if (ReqReady !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b want 1", ReqReady); end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_dtype();
    test_branch();
    test_back_to_back();
    test_backpressure();
    test_saturate();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete within 100000 ns");
    $fatal(1);
  end
endmodule
